// File: rtl/seq_det_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : seq_det_pkg
// Brief    : Shared helpers and mode encodings for the sequence detector.
// Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam logic MODE_MEALY = 1'b0;
    localparam logic MODE_MOORE = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Width needed to hold a matched-prefix length of 0..pat_len.
    function automatic int state_w(input int pat_len);
        return (clog2(pat_len + 1) < 1) ? 1 : clog2(pat_len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_next.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : seq_det_next
// Brief    : Combinational longest-prefix (KMP fallback) next-state calculator.
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_next
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = 4
) (
    input  logic [PAT_LEN-1:0]          i_pattern,
    input  logic [PAT_LEN-2:0]          i_history,
    input  logic [state_w(PAT_LEN)-1:0] i_state,
    input  logic                        i_din,
    input  logic                        i_overlap,
    output logic [state_w(PAT_LEN)-1:0] o_next_state
);

    localparam int                  c_sw   = state_w(PAT_LEN);
    localparam logic [c_sw-1:0]     c_full = c_sw'(PAT_LEN);

    logic [PAT_LEN-1:0] w_seq;
    logic [c_sw-1:0]    w_base;
    logic [PAT_LEN:1]   w_hit;

    assign w_seq  = {i_history, i_din};
    assign w_base = (i_state == c_full && !i_overlap) ? '0 : i_state;

    // A candidate k can never exceed base+1; this also masks stale history bits.
    generate
        for (genvar k = 1; k <= PAT_LEN; k++) begin : g_prefix
            assign w_hit[k] = (w_seq[k-1:0] == i_pattern[PAT_LEN-1 -: k])
                              && ((int'(w_base) + 1) >= k);
        end
    endgenerate

    always_comb begin
        o_next_state = '0;
        for (int k = 1; k <= PAT_LEN; k++) begin
            if (w_hit[k]) o_next_state = c_sw'(k);
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : seq_detector_param
// Brief    : Programmable serial sequence detector with overlap, Mealy/Moore
//            output, valid qualifier and saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PAT_RST = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_load,
    input  logic [PAT_LEN-1:0]          cfg_pattern,
    input  logic                        cfg_overlap,
    input  logic                        cfg_moore,
    input  logic                        din_valid,
    input  logic                        din,
    output logic                        match,
    output logic [CNT_W-1:0]            match_cnt,
    output logic [state_w(PAT_LEN)-1:0] state_o
);

    localparam int              c_sw   = state_w(PAT_LEN);
    localparam logic [c_sw-1:0] c_full = c_sw'(PAT_LEN);

    logic [PAT_LEN-1:0] r_pattern;
    logic               r_overlap;
    logic               r_moore;
    logic [c_sw-1:0]    r_state;
    logic [PAT_LEN-2:0] r_hist;
    logic               r_pulse;
    logic [CNT_W-1:0]   r_cnt;

    logic [c_sw-1:0]    w_next;
    logic [PAT_LEN-1:0] w_seq;

    assign w_seq = {r_hist, din};

    seq_det_next #(
        .PAT_LEN (PAT_LEN)
    ) u_next (
        .i_pattern    (r_pattern),
        .i_history    (r_hist),
        .i_state      (r_state),
        .i_din        (din),
        .i_overlap    (r_overlap),
        .o_next_state (w_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pattern <= PAT_RST;
            r_overlap <= 1'b1;
            r_moore   <= MODE_MEALY;
            r_state   <= '0;
            r_hist    <= '0;
            r_pulse   <= 1'b0;
            r_cnt     <= '0;
        end else if (cfg_load) begin
            // Load takes priority; any din beat this cycle is dropped.
            r_pattern <= cfg_pattern;
            r_overlap <= cfg_overlap;
            r_moore   <= cfg_moore;
            r_state   <= '0;
            r_hist    <= '0;
            r_pulse   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_pulse <= 1'b0;
            if (din_valid) begin
                r_state <= w_next;
                r_hist  <= w_seq[PAT_LEN-2:0];
                if (w_next == c_full) begin
                    r_pulse <= 1'b1;
                    if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign match     = (r_moore == MODE_MOORE) ? (r_state == c_full) : r_pulse;
    assign match_cnt = r_cnt;
    assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seq_detector_param
// Brief    : Vector table, directed corner cases and random model comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    localparam int L = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic       cfg_overlap;
    logic       cfg_moore;
    logic       din_valid;
    logic       din;
    logic       match, match2;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic [2:0] st, st2;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_LEN(4), .PAT_RST(4'b1101), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .cfg_moore(cfg_moore), .din_valid(din_valid),
        .din(din), .match(match), .match_cnt(cnt), .state_o(st)
    );

    seq_detector_param #(.PAT_LEN(4), .PAT_RST(4'b1101), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .cfg_moore(cfg_moore), .din_valid(din_valid),
        .din(din), .match(match2), .match_cnt(cnt2), .state_o(st2)
    );

    typedef struct {
        bit       ld;
        bit [3:0] pat;
        bit       ov;
        bit       mo;
        bit       v;
        bit       d;
        bit       em;
        int       es;
        int       ec;
    } vec_t;

    vec_t tbl[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic add_load(input bit [3:0] p, input bit ov, input bit mo);
        tbl.push_back('{1'b1, p, ov, mo, 1'b0, 1'b0, 1'b0, 0, 0});
    endtask

    // Non-load rows carry junk config that must be ignored.
    task automatic add_beat(input bit v, input bit d, input bit em, input int es, input int ec);
        tbl.push_back('{1'b0, 4'b0010, 1'b0, 1'b1, v, d, em, es, ec});
    endtask

    task automatic drive(input bit ld, input bit [3:0] p, input bit ov, input bit mo,
                         input bit v, input bit d);
        cfg_load    = ld;
        cfg_pattern = p;
        cfg_overlap = ov;
        cfg_moore   = mo;
        din_valid   = v;
        din         = d;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit d);
        drive(1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, d);
    endtask

    // Reference model: keeps the raw received bits and searches them directly.
    bit [3:0] m_pat;
    bit       m_ov, m_mo, m_pulse;
    bit       m_q[$];
    int       m_s, m_cnt, m_cnt2;

    function automatic int best_prefix();
        int n;
        bit ok;
        n = m_q.size();
        for (int k = (n < L ? n : L); k >= 1; k--) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++)
                if (m_q[n - k + i] != m_pat[L - 1 - i]) ok = 1'b0;
            if (ok) return k;
        end
        return 0;
    endfunction

    task automatic model_step(input bit ld, input bit [3:0] p, input bit ov, input bit mo,
                              input bit v, input bit d);
        if (ld) begin
            m_pat = p; m_ov = ov; m_mo = mo;
            m_q.delete();
            m_s = 0; m_pulse = 1'b0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            m_pulse = 1'b0;
            if (v) begin
                if (m_s == L && !m_ov) m_q.delete();
                m_q.push_back(d);
                if (m_q.size() > L) void'(m_q.pop_front());
                m_s = best_prefix();
                if (m_s == L) begin
                    m_pulse = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
        end
    endtask

    initial begin
        logic [12:0] sat_bits;
        bit          r_ld, r_ov, r_mo, r_v, r_d;
        bit [3:0]    r_p;

        rst = 1'b0; cfg_load = 1'b0; cfg_pattern = 4'b0; cfg_overlap = 1'b0;
        cfg_moore = 1'b0; din_valid = 1'b0; din = 1'b0;
        #2;
        chk("reset_match", match, 0);
        chk("reset_state", st, 0);
        chk("reset_cnt", cnt, 0);
        #10 rst = 1'b1;

        // Default config: 1101, overlap, Mealy
        add_beat(1,1,0,1,0); add_beat(1,1,0,2,0); add_beat(1,0,0,3,0); add_beat(1,1,1,4,1);
        add_beat(1,1,0,2,1); add_beat(1,0,0,3,1); add_beat(1,1,1,4,2); add_beat(0,0,0,4,2);
        // Non-overlap
        add_load(4'b1101, 1'b0, 1'b0);
        add_beat(1,1,0,1,0); add_beat(1,1,0,2,0); add_beat(1,0,0,3,0); add_beat(1,1,1,4,1);
        add_beat(1,1,0,1,1); add_beat(1,0,0,0,1); add_beat(1,1,0,1,1);
        // KMP fallback on 1,1,1
        add_load(4'b1101, 1'b1, 1'b0);
        add_beat(1,1,0,1,0); add_beat(1,1,0,2,0); add_beat(1,1,0,2,0); add_beat(1,0,0,3,0);
        add_beat(1,1,1,4,1);
        // Moore, 1111, held through idle cycles
        add_load(4'b1111, 1'b1, 1'b1);
        add_beat(1,1,0,1,0); add_beat(1,1,0,2,0); add_beat(1,1,0,3,0); add_beat(1,1,1,4,1);
        add_beat(1,1,1,4,2); add_beat(1,1,1,4,3);
        for (int i = 0; i < 5; i++) add_beat(0,0,1,4,3);
        add_beat(1,0,0,0,3);

        foreach (tbl[i]) begin
            drive(tbl[i].ld, tbl[i].pat, tbl[i].ov, tbl[i].mo, tbl[i].v, tbl[i].d);
            chk($sformatf("vec%0d_match", i), match, tbl[i].em);
            chk($sformatf("vec%0d_state", i), st, tbl[i].es);
            chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].ec);
        end

        // Counter saturation on the narrow instance, then load with a beat present
        drive(1'b1, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);
        sat_bits = 13'b1101101101101;
        for (int i = 12; i >= 0; i--) beat(sat_bits[i]);
        chk("sat_cnt8", cnt, 4);
        chk("sat_cnt2", cnt2, 3);
        chk("sat_match", match, 1);
        drive(1'b1, 4'b1101, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("load_cnt8", cnt, 0);
        chk("load_cnt2", cnt2, 0);
        chk("load_state", st, 0);
        beat(1'b1);
        chk("load_beat_dropped", st, 1);

        // Asynchronous reset mid-sequence restores defaults (1101, overlap, Mealy)
        drive(1'b1, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0);
        beat(1); beat(1); beat(0); beat(1); beat(1); beat(1); beat(0);
        chk("prerst_state", st, 3);
        chk("prerst_cnt", cnt, 1);
        #3 rst = 1'b0;
        #1;
        chk("arst_match", match, 0);
        chk("arst_state", st, 0);
        chk("arst_cnt", cnt, 0);
        #2 rst = 1'b1;
        beat(1);
        chk("postrst_state", st, 1);
        chk("postrst_match", match, 0);
        beat(1); beat(0); beat(1);
        chk("postrst_hit", match, 1);
        drive(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("postrst_mealy", match, 0);
        beat(1); beat(0); beat(1);
        chk("postrst_overlap", match, 1);
        chk("postrst_cnt", cnt, 2);

        // Random stimulus against the reference model
        for (int i = 0; i < 3000; i++) begin
            r_ld = (i == 0) || ($urandom_range(0, 79) == 0);
            r_p  = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
            r_ov = 1'($urandom_range(0, 1));
            r_mo = 1'($urandom_range(0, 1));
            r_v  = ($urandom_range(0, 3) != 0);
            r_d  = 1'($urandom_range(0, 1));
            model_step(r_ld, r_p, r_ov, r_mo, r_v, r_d);
            drive(r_ld, r_p, r_ov, r_mo, r_v, r_d);
            chk("rnd_state", st, m_s);
            chk("rnd_state2", st2, m_s);
            chk("rnd_cnt", cnt, m_cnt);
            chk("rnd_cnt2", cnt2, m_cnt2);
            chk("rnd_match", match, m_mo ? int'(m_s == L) : int'(m_pulse));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-sequence detector; next generation of the team's fixed 4-bit Mealy/Moore sequence checkers.
- Pattern length is set by parameter; the pattern value is runtime-programmable.
- Adds overlap/non-overlap mode, selectable Mealy (pulse) or Moore (held) output, a valid-qualified input and a saturating match counter.
- Sits after bit-serial receivers (UART/line decoders) as a sync-word/marker detector.

Parameters:
- PAT_LEN, 4: pattern length in bits, 2..16.
- PAT_RST, 4'b1101: pattern value after reset, PAT_LEN bits.
- CNT_W, 8: match counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cfg_load  in  1  one-cycle pulse; latches cfg_pattern, cfg_overlap and cfg_moore, then restarts detection
- cfg_pattern  in  PAT_LEN  pattern; bit PAT_LEN-1 is the first bit received
- cfg_overlap  in  1  1 = overlapping matches allowed
- cfg_moore  in  1  1 = Moore (held) output; 0 = Mealy (pulse) output
- din_valid  in  1  din is sampled only when high
- din  in  1  serial data bit
- match  out  1  match indication
- match_cnt  out  CNT_W  saturating count of matches
- state_o  out  clog2(PAT_LEN+1)  current matched-prefix length (debug)

Behaviour:
- Reset values: state 0, match 0, match_cnt 0, pattern = PAT_RST, overlap = 1, moore = 0.
- State S = number of pattern bits currently matched, 0..PAT_LEN. S = PAT_LEN is the terminal/matched state.
- Only beats with din_valid = 1 advance S. With din_valid = 0, S holds.
- Transition for S < PAT_LEN on a valid beat: next S = longest k such that the last k received bits, including din, equal the first k pattern bits. This is a full KMP fallback, not a reset to 0.
  - Example, pattern 1101: stream 1,1,1 stays at S = 2.
- Transition from S = PAT_LEN on a valid beat:
  - overlap = 1: same rule applied to the full matched sequence plus din.
  - overlap = 0: evaluated as if from S = 0 with din.
- Next-state logic is combinational over k = PAT_LEN..1, driven by a registered history of the last PAT_LEN-1 valid bits.
- Mealy mode (moore = 0):
  - match is registered; it is high for exactly one cycle, the cycle after the valid beat that moves S to PAT_LEN.
  - It is low at all other times, including while S holds at PAT_LEN.
- Moore mode (moore = 1):
  - match = (S == PAT_LEN), decoded from the state register.
  - It rises the cycle after the completing beat and stays high until the next valid beat leaves S = PAT_LEN.
  - A valid beat that re-enters PAT_LEN keeps match high.
- match_cnt:
  - Increments on every valid beat that yields next S = PAT_LEN, in both modes, and updates in the same cycle as Mealy match.
  - Saturates at all-ones with no wrap.
- cfg_load:
  - On the next edge: pattern, overlap and moore are updated; S, history and match are cleared; match_cnt is cleared.
  - A din beat in the same cycle is discarded (load wins).
- cfg_pattern, cfg_overlap and cfg_moore are ignored when cfg_load = 0.
- Reset asserted mid-sequence: all state returns to reset values immediately (asynchronous). The first valid beat after deassertion starts from S = 0.
- Pattern of all identical bits: fallback from PAT_LEN in overlap mode gives PAT_LEN again on the same bit (a match every beat).

Decomposition:
- Package seq_det_pkg holds:
  - function clog2;
  - localparam mode encodings MODE_MEALY = 0 and MODE_MOORE = 1;
  - the state-width function used by ports.
- Sub-module seq_det_next: purely combinational next-state calculator.
  - Inputs: pattern, history, S, din, overlap.
  - Output: next S.
- The top level holds the registers, output logic, counter and config shadow.

Test Plan:
- Pattern 1101, overlap = 1, Mealy, stream 1,1,0,1,1,0,1 (all valid) -> match pulses after beats 4 and 7; match_cnt = 2.
- Same stream, overlap = 0 -> single pulse after beat 4; match_cnt = 1; state_o = 1 after beat 7.
- Pattern 1101, stream 1,1,1,0,1 -> state_o sequence 1,2,2,3,4; one pulse after beat 5 (fallback check).
- Pattern 1111 loaded via cfg_load, Moore, overlap = 1, stream 1 x6, then din_valid = 0 for 5 cycles -> match high from after beat 4 through all idle cycles; match_cnt = 3. Then a beat of 0 drops match the following cycle.
- CNT_W = 2, pattern 1101, overlap = 1, stream 1101101101101 -> 4 matches; match_cnt saturates at 3. Then cfg_load with din_valid = 1 -> count 0, state 0, beat ignored.
- Feed 1,1,0 then assert rst asynchronously mid-cycle -> match = 0, state_o = 0 immediately. After release, feed 1 -> no match.
